// File: rtl/display_pkg.sv
// display_pkg: active-low segment codes ({g,f,e,d,c,b,a}) shared by the
// hex decoder and the scanning display driver.
package display_pkg;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // All segments off (active-low).
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

endpackage

// File: rtl/decodificador_hex.sv
// decodificador_hex: combinational 4-bit hex to active-low 7-segment decoder.
module decodificador_hex
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Table lookup of the segment pattern for one hex digit.
  always_comb begin
    seg_o = SEG_APAGADO;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/display_varredura.sv
// display_varredura: multiplexed driver for N common-anode 7-segment digits.
// Latches a packed hex word on `carga`, scans one digit every DIV_VARREDURA
// cycles and drives registered active-low anode/segment/point pins, with a
// one-cycle `fim_quadro` pulse when digit 0 is shown again after a wrap.
// Optional feature: define SUPRESSAO_ZEROS_EN to blank leading zero digits.
module display_varredura
  import display_pkg::*;
#(
  parameter int N_DIGITOS     = 4,
  parameter int DIV_VARREDURA = 50000
)
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   carga,
  input  logic [4*N_DIGITOS-1:0] valor,
  input  logic [N_DIGITOS-1:0]   pontos,
  input  logic                   habilita,
  output logic [N_DIGITOS-1:0]   anodos,
  output logic [6:0]             segmentos,
  output logic                   ponto,
  output logic                   fim_quadro
);

  localparam int IW = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
  localparam int CW = $clog2(DIV_VARREDURA);
  localparam logic [IW-1:0] IDX_ULT = IW'(N_DIGITOS - 1);
  localparam logic [CW-1:0] CNT_ULT = CW'(DIV_VARREDURA - 1);

  genvar gi;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [4*N_DIGITOS-1:0] dado_q, dado_d;
  logic [N_DIGITOS-1:0]   pontos_q, pontos_d;
  logic                   wrap_q, wrap_d;
  logic [N_DIGITOS-1:0]   anodos_q, anodos_d;
  logic [6:0]             seg_q, seg_d;
  logic                   ponto_q, ponto_d;
  logic                   fim_q, fim_d;

  logic                   tick;
  logic [3:0]             digito;
  logic                   ponto_sel;
  logic [6:0]             seg_dec;
  logic                   apagar;

  assign tick = (cnt_q == CNT_ULT);

  // Prescaler, digit index, wrap marker and shadow-register next state.
  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_ULT) ? '0 : idx_q + 1'b1;
    end
    // The wrap is delayed one cycle so the pulse lines up with digit 0 on the pins.
    wrap_d   = tick && (idx_q == IDX_ULT);
    dado_d   = carga ? valor  : dado_q;
    pontos_d = carga ? pontos : pontos_q;
  end

  // Select the nibble and decimal-point request of the digit being scanned.
  always_comb begin
    digito    = 4'h0;
    ponto_sel = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (idx_q == IW'(i)) begin
        digito    = dado_q[4*i +: 4];
        ponto_sel = pontos_q[i];
      end
    end
  end

  decodificador_hex u_decodificador (
    .nibble_i (digito),
    .seg_o    (seg_dec)
  );

`ifdef SUPRESSAO_ZEROS_EN
  // zeros_acima[i]: digit i and every more-significant digit are zero.
  // Digit 0 is never blanked so a zero value still shows a single 0.
  logic [N_DIGITOS-1:0] zeros_acima;
  assign zeros_acima[0] = 1'b0;
  for (gi = 1; gi < N_DIGITOS; gi++) begin : g_zeros
    assign zeros_acima[gi] = ~|dado_q[4*N_DIGITOS-1:4*gi];
  end

  // Blank flag of the digit being scanned.
  always_comb begin
    apagar = 1'b0;
    for (int i = 0; i < N_DIGITOS; i++) begin
      if (idx_q == IW'(i)) begin
        apagar = zeros_acima[i];
      end
    end
  end
`else
  assign apagar = 1'b0;
`endif

  // One-hot-low anode select; habilita only gates anodes, the scan keeps running.
  for (gi = 0; gi < N_DIGITOS; gi++) begin : g_anodos
    assign anodos_d[gi] = ~(habilita && (idx_q == IW'(gi)));
  end

  assign seg_d   = apagar ? SEG_APAGADO : seg_dec;
  assign ponto_d = ~ponto_sel;
  assign fim_d   = wrap_q;

  // State and output registers; reset wins over a coincident carga.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      dado_q   <= '0;
      pontos_q <= '0;
      wrap_q   <= 1'b0;
      anodos_q <= '1;
      seg_q    <= SEG_APAGADO;
      ponto_q  <= 1'b1;
      fim_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dado_q   <= dado_d;
      pontos_q <= pontos_d;
      wrap_q   <= wrap_d;
      anodos_q <= anodos_d;
      seg_q    <= seg_d;
      ponto_q  <= ponto_d;
      fim_q    <= fim_d;
    end
  end

  assign anodos     = anodos_q;
  assign segmentos  = seg_q;
  assign ponto      = ponto_q;
  assign fim_quadro = fim_q;

endmodule

// File: doc/display_varredura.md
# display_varredura

Multiplexed driver for N common-anode 7-segment digits, the parametrised successor of the single-digit hex decoder. It latches a packed hex word on a load strobe and scans the digits at a fixed divided rate, one anode at a time. It produces active-low segment, decimal-point and anode signals and pulses a frame marker once per full scan. It sits between the datapath result registers and the board display pins.

## Interface
- N_DIGITOS, 4: number of digits scanned (1..8).
- DIV_VARREDURA, 50000: clock cycles each digit stays lit (≥2).
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- carga  input  1  load strobe; captures `valor` and `pontos` on the edge where it is high.
- valor  input  4*N_DIGITOS  packed hex digits; digit 0 = bits [3:0] (least significant).
- pontos  input  N_DIGITOS  decimal-point request per digit, 1 = lit.
- habilita  input  1  1 = display on, 0 = blank all anodes while scanning continues.
- anodos  output  N_DIGITOS  anode select, active-low, one-hot-low when enabled.
- segmentos  output  7  segments {g,f,e,d,c,b,a}, active-low.
- ponto  output  1  decimal point, active-low.
- fim_quadro  output  1  one-cycle pulse when the scan wraps from digit N-1 to digit 0.

## Operation
- Shadow registers `dado_r` (4*N bits) and `ponto_r` (N bits) load on `carga`. They hold otherwise.
- Prescaler counts 0..DIV_VARREDURA-1. The terminal count is `tick`.
- On `tick`, the digit index advances 0→1→…→N-1→0. On the N-1→0 wrap, `fim_quadro`=1 for that cycle.
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Outputs are registered from the current index and the shadow registers. `anodos` has bit[index]=0 and all other bits 1.
- `habilita`=0: `anodos` all 1. `segmentos`, `ponto` and the index keep updating.
- N_DIGITOS=1: the index stays 0. `fim_quadro` pulses on every `tick`.

## Timing
- Reset values:
  - `anodos`=all 1, `segmentos`=1111111, `ponto`=1, `fim_quadro`=0.
  - Index=0, prescaler=0, `dado_r`=0, `ponto_r`=0.
- Reset asserted mid-scan: all of the above take effect on the next edge. Any `carga` in that cycle is ignored.
- Output latency is 1 cycle from an index change or a shadow-register update to the pins.
- `carga` asserted on edge k: the pins show the new data of the currently selected digit from edge k+1.
- `carga` held high: loads every cycle and the display tracks `valor` live.
- `carga` and `tick` on the same edge: both apply. Edge k+1 shows the new data on the new digit.
- First digit lit after reset: digit 0, on the first edge with reset low. Each digit is lit for exactly DIV_VARREDURA cycles.
- `fim_quadro` is registered and is high during the cycle in which digit 0 is first shown after a wrap.

## Configuration
- SUPRESSAO_ZEROS_EN defined:
  - A digit i>0 is blanked (`segmentos`=1111111) when it and all more-significant digits of `dado_r` are 0.
  - Digit 0 is never blanked.
  - `ponto` still follows `ponto_r` for blanked digits.
  - The anode still sweeps blanked positions, so scan timing is unchanged.
- Undefined: every digit is decoded, leading zeros included.

## Structure
- Package `display_pkg`: localparams for the 16 segment codes and SEG_APAGADO=7'b1111111.
- Sub-module `decodificador_hex`: purely combinational, 4-bit in, 7-bit out, uses the package codes. Instantiated once on the mux output.
- Top holds the prescaler, index counter, shadow registers, optional zero-suppression logic and output registers.

## Test plan
- Reset, then N=4, DIV=4, `valor`=16'h1234 with `carga` pulsed -> `anodos` cycles 1110,1101,1011,0111 every 4 cycles; `segmentos` are 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1); `fim_quadro` pulses every 16 cycles.
- Load 16'hABCD, then 16'hEF09 mid-digit -> the current digit changes to the new code one cycle after `carga`; decode matches the table, with d=0100001 and F=0001110.
- `habilita`=0 for 10 cycles -> `anodos`=1111 throughout; the index keeps advancing and the scan resumes in phase when `habilita` returns to 1.
- With SUPRESSAO_ZEROS_EN, load 16'h0070 and `pontos`=4'b1000 -> digit 3 is blank with `ponto`=0, digit 2 is blank, digit 1=1111000, digit 0=1000000. Load 16'h0000 -> only digit 0 shows 0.
- Assert `reset` at the middle of digit 2 -> the next edge gives all outputs at their reset values; after release, digit 0 is lit with 1000000.
- `carga` coinciding with `tick` -> the next cycle shows the next digit with the newly loaded value.
